// File: rtl/avalon_pio_pkg.sv
// rtl/avalon_pio_pkg.sv - register map, edge modes and edge-event helper for the PIO peripheral
package avalon_pio_pkg;

    localparam logic [2:0] ADDR_OUT      = 3'd0;
    localparam logic [2:0] ADDR_IN       = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR   = 3'd5;
    localparam logic [2:0] ADDR_PULSE    = 3'd6;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    function automatic logic edge_event(input logic cur, input logic prev, input int etype);
        case (etype)
            EDGE_RISE: return cur & ~prev;
            EDGE_FALL: return ~cur & prev;
            default:   return cur ^ prev;
        endcase
    endfunction

endpackage

// File: rtl/pio_pulse_timer.sv
// rtl/pio_pulse_timer.sv - reloadable down-counter driving a self-timed pulse of programmable polarity
module pio_pulse_timer #(
    parameter int CNT_W  = 16,
    parameter bit ACTIVE = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] count,
    output logic             pulse_out
);

    // A load in the same cycle as a decrement wins, so a rewrite always restarts the full length.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign pulse_out = (count != '0) ? ACTIVE : ~ACTIVE;

endmodule

// File: rtl/avalon_pio_ctrl.sv
// rtl/avalon_pio_ctrl.sv - Avalon-MM PIO slave: output bank with set/clear, edge-capture IRQ, pulse timer
module avalon_pio_ctrl
    import avalon_pio_pkg::*;
#(
    parameter int                   OUT_WIDTH    = 8,
    parameter int                   IN_WIDTH     = 8,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET    = '0,
    parameter int                   EDGE_TYPE    = 0,
    parameter int                   PULSE_CNT_W  = 16,
    parameter bit                   PULSE_ACTIVE = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    output logic [OUT_WIDTH-1:0] out_port,
    input  logic [IN_WIDTH-1:0]  in_port,
    output logic                 pulse_out,
    output logic                 irq
);

    logic                   wr;
    logic [OUT_WIDTH-1:0]   out_reg;
    logic [IN_WIDTH-1:0]    irq_mask;
    logic [IN_WIDTH-1:0]    edge_cap;
    logic [IN_WIDTH-1:0]    s1;
    logic [IN_WIDTH-1:0]    in_sync;
    logic [IN_WIDTH-1:0]    in_prev;
    logic [IN_WIDTH-1:0]    edge_ev;
    logic [IN_WIDTH-1:0]    cap_clr;
    logic [PULSE_CNT_W-1:0] pulse_count;
    logic                   unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_reg  <= OUT_RESET;
            irq_mask <= '0;
        end else if (wr) begin
            case (address)
                ADDR_OUT:      out_reg  <= writedata[OUT_WIDTH-1:0];
                ADDR_OUTSET:   out_reg  <= out_reg | writedata[OUT_WIDTH-1:0];
                ADDR_OUTCLR:   out_reg  <= out_reg & ~writedata[OUT_WIDTH-1:0];
                ADDR_IRQ_MASK: irq_mask <= writedata[IN_WIDTH-1:0];
                default:       ;
            endcase
        end
    end

    always_comb begin
        edge_ev = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            edge_ev[i] = edge_event(in_sync[i], in_prev[i], EDGE_TYPE);
        end
    end

    assign cap_clr = (wr && address == ADDR_EDGE_CAP) ? writedata[IN_WIDTH-1:0] : '0;

    // New events are OR-ed in after the clear so a coincident edge is never lost.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1       <= '0;
            in_sync  <= '0;
            in_prev  <= '0;
            edge_cap <= '0;
            irq      <= 1'b0;
        end else begin
            s1       <= in_port;
            in_sync  <= s1;
            in_prev  <= in_sync;
            edge_cap <= (edge_cap & ~cap_clr) | edge_ev;
            irq      <= |(edge_cap & irq_mask);
        end
    end

    pio_pulse_timer #(
        .CNT_W  (PULSE_CNT_W),
        .ACTIVE (PULSE_ACTIVE)
    ) u_pulse (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (wr && address == ADDR_PULSE),
        .load_value (writedata[PULSE_CNT_W-1:0]),
        .count      (pulse_count),
        .pulse_out  (pulse_out)
    );

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_OUT:      readdata = 32'(out_reg);
            ADDR_IN:       readdata = 32'(in_sync);
            ADDR_IRQ_MASK: readdata = 32'(irq_mask);
            ADDR_EDGE_CAP: readdata = 32'(edge_cap);
            ADDR_PULSE:    readdata = 32'(pulse_count);
            default:       readdata = '0;
        endcase
    end

    assign out_port = out_reg;

endmodule

// File: tb/tb_avalon_pio_ctrl.sv
// tb/tb_avalon_pio_ctrl.sv - scoreboard bench for avalon_pio_ctrl, active-high and active-low pulse builds
module tb_avalon_pio_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata, readdata_n;
    logic [7:0]  out_port, out_port_n;
    logic        pulse_out, pulse_out_n;
    logic        irq, irq_n;

    int n_checks = 0;
    int n_fail   = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    avalon_pio_ctrl #(
        .OUT_WIDTH(8), .IN_WIDTH(8), .OUT_RESET(8'hA5),
        .EDGE_TYPE(0), .PULSE_CNT_W(16), .PULSE_ACTIVE(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .in_port(in_port), .pulse_out(pulse_out), .irq(irq)
    );

    avalon_pio_ctrl #(
        .OUT_WIDTH(8), .IN_WIDTH(8), .OUT_RESET(8'hA5),
        .EDGE_TYPE(0), .PULSE_CNT_W(16), .PULSE_ACTIVE(1'b0)
    ) dut_n (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata_n),
        .out_port(out_port_n), .in_port(in_port), .pulse_out(pulse_out_n), .irq(irq_n)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow: got 0x%0h with no expectation queued", obs);
        end else begin
            check_value(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        sb_push(tag, exp);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        sb_pop(readdata);
        chipselect = 1'b0;
    endtask

    task automatic obs(input string tag, input logic [31:0] actual, input logic [31:0] exp);
        sb_push(tag, exp);
        sb_pop(actual);
    endtask

    initial begin
        int hi;
        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0;
        tick(); tick();
        obs("rst_out", 32'(out_port), 32'hA5);
        obs("rst_pulse", 32'(pulse_out), 0);
        obs("rst_pulse_n", 32'(pulse_out_n), 1);
        obs("rst_irq", 32'(irq), 0);
        rd("rst_cap", 3'd3, 0);
        reset_n = 1'b1;
        tick();

        wr(3'd0, 32'h0F); obs("out_load", 32'(out_port), 32'h0F);
        wr(3'd4, 32'hF0); obs("out_set", 32'(out_port), 32'hFF);
        wr(3'd5, 32'h81); obs("out_clr", 32'(out_port), 32'h7E);
        rd("rd_outset", 3'd4, 0);
        rd("rd_outclr", 3'd5, 0);
        rd("rd_out", 3'd0, 32'h7E);

        wr(3'd2, 32'h04);
        rd("rd_mask", 3'd2, 32'h04);
        in_port = 8'h04;
        tick(); tick();
        rd("cap_early", 3'd3, 0);
        tick();
        rd("cap_lat3", 3'd3, 32'h04);
        obs("irq_lag", 32'(irq), 0);
        tick();
        obs("irq_set", 32'(irq), 1);
        wr(3'd3, 32'h04);
        rd("cap_w1c", 3'd3, 0);
        tick();
        obs("irq_clr", 32'(irq), 0);
        in_port = 8'h0C;
        tick(); tick(); tick();
        rd("cap_bit3", 3'd3, 32'h08);
        rd("cap_noside", 3'd3, 32'h08);
        tick();
        obs("irq_masked", 32'(irq), 0);

        wr(3'd3, 32'hFF);
        rd("cap_clrall", 3'd3, 0);
        in_port = 8'h08;
        tick(); tick(); tick();
        in_port = 8'h0C;
        tick(); tick();
        wr(3'd3, 32'h04);
        rd("cap_collide", 3'd3, 32'h04);
        rd("rd_in", 3'd1, 32'h0C);

        wr(3'd6, 32'd5);
        obs("pulse_n_act", 32'(pulse_out_n), 0);
        for (int i = 0; i < 5; i++) begin
            obs("pulse5_hi", 32'(pulse_out), 1);
            rd("pulse5_cnt", 3'd6, 32'(5 - i));
            tick();
        end
        obs("pulse5_end", 32'(pulse_out), 0);
        rd("pulse5_cnt0", 3'd6, 0);

        hi = 0;
        wr(3'd6, 32'd10);
        repeat (3) begin
            if (pulse_out) hi++;
            tick();
        end
        if (pulse_out) hi++;
        wr(3'd6, 32'd3);
        for (int i = 0; i < 50 && pulse_out; i++) begin
            hi++;
            tick();
        end
        obs("pulse_reload", 32'(hi), 7);

        wr(3'd6, 32'd20);
        tick(); tick();
        obs("pulse_mid", 32'(pulse_out), 1);
        wr(3'd6, 32'd0);
        obs("pulse_zero", 32'(pulse_out), 0);

        wr(3'd6, 32'd100);
        repeat (18) tick();
        rd("pulse_cnt19", 3'd6, 32'd82);
        reset_n = 1'b0;
        tick();
        obs("rstmid_pulse", 32'(pulse_out), 0);
        obs("rstmid_pulse_n", 32'(pulse_out_n), 1);
        rd("rstmid_cnt", 3'd6, 0);
        obs("rstmid_out", 32'(out_port), 32'hA5);
        reset_n = 1'b1;
        tick(); tick();
        obs("idle_pulse", 32'(pulse_out), 0);
        obs("idle_pulse_n", 32'(pulse_out_n), 1);

        check_value("sb_drain", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
